// File: rtl/esn_pkg.sv
// Shared types and helpers for the ESN row multiplier datapath.
package esn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } esnState_t;

  function automatic int prodWidth(input int dataWidth, input int weightWidth);
    return dataWidth + weightWidth - 1;
  endfunction

  function automatic int clog2(input int value);
    for (int w = 0; w < 31; w++) begin
      if ((1 << w) >= value) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/esn_mul_sat.sv
// One signed state*weight product reduced to demention bits.
// ESN_PROD_SAT_EN: saturate the single overflowing product instead of wrapping.
module esn_mul_sat
  import esn_pkg::*;
#(
  parameter int data_width = 3,
  parameter int weight_size = 2,
  localparam int demention = prodWidth(data_width, weight_size)
) (
  input  logic signed [data_width-1:0]  iA,
  input  logic signed [weight_size-1:0] iB,
  output logic        [demention-1:0]   oP
);

  logic signed [demention:0] full;

  assign full = (demention + 1)'(iA) * (demention + 1)'(iB);

`ifdef ESN_PROD_SAT_EN
  // Only min*min overflows, landing on +2^(D-1): the top two bits then disagree.
  assign oP = (full[demention] != full[demention-1]) ?
              {1'b0, {(demention-1){1'b1}}} : full[demention-1:0];
`else
  logic unusedTop;
  assign unusedTop = full[demention];
  assign oP = full[demention-1:0];
`endif

endmodule

// File: rtl/esn_row_multiplier.sv
// Holds the reservoir weight matrix, latches a state vector and streams one
// row of element-wise products per transfer to the normaliser adder tree.
module esn_row_multiplier
  import esn_pkg::*;
#(
  parameter int data_width = 3,
  parameter int weight_size = 2,
  parameter int reservoir_size = 4,
  localparam int demention = prodWidth(data_width, weight_size),
  localparam int rowW = clog2(reservoir_size),
  localparam int addrW = clog2(reservoir_size * reservoir_size)
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iWeWr,
  input  logic [addrW-1:0]                    iWeAddr,
  input  logic signed [weight_size-1:0]       iWeData,
  input  logic                                iStart,
  input  logic [data_width*reservoir_size-1:0] iState,
  output logic                                oBusy,
  output logic [demention*reservoir_size-1:0] oData,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [rowW-1:0]                     oRow,
  output logic                                oLast
);

  localparam int N = reservoir_size;

  esnState_t state, nextState;
  logic [rowW-1:0] rowCnt;
  logic signed [weight_size-1:0] weights [N*N];
  logic signed [data_width-1:0] stateLat [N];
  logic [demention*N-1:0] prodVec;
  logic accept;
  logic load;

  assign accept = (state == IDLE) && iStart;
  assign load   = (state == RUN) && (!oValid || iReady);
  assign oBusy  = (state != IDLE);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = RUN;
      RUN:     if (load && (rowCnt == rowW'(N - 1))) nextState = DRAIN;
      DRAIN:   if (oValid && iReady && oLast) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // W is frozen for the whole pass; writes outside IDLE are dropped.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < N * N; i++) weights[i] <= '0;
    end else if (iWeWr && (state == IDLE)) begin
      weights[iWeAddr] <= iWeData;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < N; i++) stateLat[i] <= '0;
      rowCnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) stateLat[i] <= iState[(i+1)*data_width-1 -: data_width];
      rowCnt <= '0;
    end else if (load) begin
      rowCnt <= rowCnt + rowW'(1);
    end
  end

  for (genvar g = 0; g < N; g++) begin : genMul
    localparam logic [rowW-1:0] colIdx = rowW'(g);
    esn_mul_sat #(
      .data_width (data_width),
      .weight_size(weight_size)
    ) uMul (
      .iA(stateLat[g]),
      .iB(weights[{rowCnt, colIdx}]),
      .oP(prodVec[(g+1)*demention-1 -: demention])
    );
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oValid <= 1'b0;
      oData  <= '0;
      oRow   <= '0;
      oLast  <= 1'b0;
    end else if (load) begin
      oValid <= 1'b1;
      oData  <= prodVec;
      oRow   <= rowCnt;
      oLast  <= (rowCnt == rowW'(N - 1));
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_esn_row_multiplier.sv
// Scoreboard bench for esn_row_multiplier (N=4, data_width=3, weight_size=2, D=4).
module tb_esn_row_multiplier;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iWeWr;
  logic [3:0]  iWeAddr;
  logic [1:0]  iWeData;
  logic        iStart;
  logic [11:0] iState;
  logic        oBusy;
  logic [15:0] oData;
  logic        oValid;
  logic        iReady;
  logic [1:0]  oRow;
  logic        oLast;

  esn_row_multiplier #(
    .data_width(3),
    .weight_size(2),
    .reservoir_size(4)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iWeWr(iWeWr), .iWeAddr(iWeAddr), .iWeData(iWeData),
    .iStart(iStart), .iState(iState), .oBusy(oBusy), .oData(oData), .oValid(oValid),
    .iReady(iReady), .oRow(oRow), .oLast(oLast)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic        last;
    logic [1:0]  row;
    logic [15:0] data;
  } expRow_t;

  expRow_t expQ[$];
  int nChecks = 0;
  int nPass = 0;

`ifdef ESN_PROD_SAT_EN
  localparam logic [15:0] ROW0_OVF = 16'h00A7;
`else
  localparam logic [15:0] ROW0_OVF = 16'h00A8;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [11:0] packState(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  task automatic pushRow(input int row, input logic [15:0] data);
    expRow_t e;
    e.last = (row == 3);
    e.row  = 2'(row);
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic pushPass(input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] r2, input logic [15:0] r3);
    pushRow(0, r0); pushRow(1, r1); pushRow(2, r2); pushRow(3, r3);
  endtask

  task automatic writeW(input int addr, input int data);
    iWeWr = 1'b1; iWeAddr = 4'(addr); iWeData = 2'(data);
    @(posedge iClk); #1;
    iWeWr = 1'b0;
  endtask

  task automatic startPass(input logic [11:0] st);
    iStart = 1'b1; iState = st;
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!oBusy && !oValid) break;
      @(posedge iClk); #1;
    end
    check({name, " idle"}, 32'({oBusy, oValid}), 32'd0);
    check({name, " queue empty"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: every presented row must match the queue head; it pops on transfer.
  always @(negedge iClk) begin
    if (!iRst && oValid) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("FAIL unexpected row: got row %0d data %h, none expected", oRow, oData);
      end else begin
        check("row out", 32'({oLast, oRow, oData}), 32'(expQ[0]));
        if (iReady) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] s1, s2, other;
    s1 = packState(3, -1, 2, -4);
    s2 = packState(-4, 3, 2, -1);
    other = packState(1, 1, 1, 1);
    iRst = 1'b1; iWeWr = 1'b0; iWeAddr = '0; iWeData = '0;
    iStart = 1'b0; iState = '0; iReady = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check("reset outputs", 32'({oBusy, oValid, oRow, oLast, oData}), 32'd0);
    iRst = 1'b0;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) writeW(r * 4 + c, (r == c) ? 1 : 0);

    // Identity weights: each row passes through its own state element.
    pushPass(16'h0003, 16'h00F0, 16'h0200, 16'hC000);
    startPass(s1);
    check("no valid one edge after start", 32'(oValid), 32'd0);
    check("busy after start", 32'(oBusy), 32'd1);
    @(posedge iClk); #1;
    check("first valid two edges after start", 32'({oValid, oRow}), 32'({1'b1, 2'd0}));
    waitIdle("identity");

    // Overflow corner and a normal negative product in row 0.
    writeW(0, -2);
    writeW(1, -2);
    pushPass(ROW0_OVF, 16'h0030, 16'h0200, 16'hF000);
    startPass(s2);
    waitIdle("overflow");

    // Backpressure on row 1 for three cycles.
    pushPass(ROW0_OVF, 16'h0030, 16'h0200, 16'hF000);
    startPass(s2);
    for (int i = 0; i < 10; i++) begin
      if (oValid && oRow == 2'd1) break;
      @(posedge iClk); #1;
    end
    check("row 1 presented", 32'({oValid, oRow}), 32'({1'b1, 2'd1}));
    iReady = 1'b0;
    repeat (3) begin
      @(posedge iClk); #1;
    end
    check("still busy while stalled", 32'(oBusy), 32'd1);
    iReady = 1'b1;
    waitIdle("backpressure");

    // Write and start mid-pass, plus a start during the final transfer: all ignored.
    pushPass(ROW0_OVF, 16'h0030, 16'h0200, 16'hF000);
    startPass(s2);
    iWeWr = 1'b1; iWeAddr = 4'd5; iWeData = 2'(-1);
    iStart = 1'b1; iState = other;
    @(posedge iClk); #1;
    iWeWr = 1'b0; iStart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (oValid && oLast) break;
      @(posedge iClk); #1;
    end
    check("last row presented", 32'({oValid, oLast}), 32'd3);
    iStart = 1'b1; iState = other;
    @(posedge iClk); #1;
    iStart = 1'b0;
    waitIdle("ignored start");
    repeat (2) @(posedge iClk);
    #1;
    check("no extra pass", 32'({oBusy, oValid}), 32'd0);

    // The same write in IDLE lands on the next pass.
    writeW(5, -1);
    pushPass(ROW0_OVF, 16'h00D0, 16'h0200, 16'hF000);
    startPass(s2);
    waitIdle("idle write");

    // Reset after row 1 is accepted aborts the pass and clears W.
    pushPass(ROW0_OVF, 16'h00D0, 16'h0200, 16'hF000);
    startPass(s2);
    repeat (3) begin
      @(posedge iClk); #1;
    end
    check("rows 0 and 1 accepted", 32'(expQ.size()), 32'd2);
    iRst = 1'b1;
    #1;
    check("reset mid-pass", 32'({oBusy, oValid}), 32'd0);
    expQ.delete();
    @(posedge iClk); #1;
    iRst = 1'b0;
    pushPass(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    startPass(s1);
    waitIdle("after reset");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
